shift_arbiter_2r: RTL and testbench
===================================

// Module: shift_arbiter_2r
// PURPOSE
//  Shares one 32-bit shifter (SLL/SRL/SRA) between two requesters, e.g. the ALU
//  issue port and a multi-cycle helper unit (CSR/mul-div sequencer).
//  Round-robin arbitration, valid/ready handshakes on both sides.
//  One registered response slot: 1-cycle latency, 1 op/cycle throughput.
// PARAMETERS
//  DATA_W   32              operand/result width
//  SHAMT_W  $clog2(DATA_W)  shift amount width (5 for 32b); derived, do not override
// PORTS
//  clk         in   1        clock, all state on rising edge
//  rst_n       in   1        asynchronous active-low reset
//  req0_valid  in   1        requester 0 has an op
//  req0_ready  out  1        requester 0 op accepted this cycle (valid&ready)
//  req0_op     in   2        00 SLL, 01 SRL, 10 SRA, 11 illegal
//  req0_data   in   DATA_W   operand
//  req0_shamt  in   SHAMT_W  shift amount
//  req1_*      (same five ports, requester 1)
//  resp_valid  out  1        response slot holds a result
//  resp_ready  in   1        consumer takes result this cycle
//  resp_data   out  DATA_W   shift result
//  resp_src    out  1        requester that issued the op (0/1)
//  resp_err    out  1        op was 11 (illegal)
// BEHAVIOUR
//  State: resp slot (valid, data, src, err), last_grant_q (1b).
//  Reset (async, rst_n low): resp_valid=0, resp_data=0, resp_src=0, resp_err=0,
//   last_grant_q=1; req0_ready=req1_ready=0 forced while rst_n low.
//   Reset mid-operation discards any pending response; no replay.
//  can_accept = !resp_valid | resp_ready (slot empty or draining this cycle).
//  Grant (comb): only one valid -> that one; both valid -> the one != last_grant_q
//   (req0 wins the first tie after reset); none valid -> no grant.
//  reqN_ready = can_accept & grant==N; never both high; may depend on reqN_valid.
//  resp_valid/data/src/err never depend combinationally on resp_ready.
//  On accept (edge): resp_data <= shift(data,shamt,op); resp_src <= N;
//   resp_err <= (op==11); resp_valid <= 1; last_grant_q <= N.
//  No accept and resp_valid&resp_ready: resp_valid <= 0 (data/src/err hold).
//  Accept and drain in same cycle: slot reloaded, resp_valid stays 1 (no bubble).
//  resp_valid & !resp_ready: all resp_* held stable; both readies low.
//  Unaccepted requester must hold valid/op/data/shamt; block does not latch them.
//  Arithmetic: SLL zero-fills LSBs; SRL zero-fills MSBs; SRA fills with data[31];
//   shamt=0 -> data unchanged; shamt full range 0..31, no masking needed.
//   op 11 -> resp_data=0, resp_err=1, still consumes a slot and a grant.
//  Latency: accept at edge N -> resp_valid high after edge N, visible cycle N+1.
//  last_grant_q updates only on accept; idle cycles keep priority unchanged.
// TESTING
//  T1 reset: rst_n low mid-stream with resp_valid=1 -> all resp_* 0, readies 0
//   immediately (async); after release req0 wins first tie.
//  T2 single ops, resp_ready=1: req0 SLL 0x0000_0001 sh 31 -> 0x8000_0000;
//   SRL 0x8000_0000 sh 4 -> 0x0800_0000; SRA 0x8000_0000 sh 4 -> 0xF800_0000;
//   sh 0 of 0xDEAD_BEEF -> 0xDEAD_BEEF; each resp one cycle after accept, src=0.
//  T3 contention: both valid continuously, resp_ready=1 -> grants alternate
//   0,1,0,1 for 8 cycles, one resp per cycle, resp_src matches grant order.
//  T4 backpressure: resp_ready=0 for 5 cycles with resp pending -> readies 0,
//   resp_* stable; raise resp_ready -> next op accepted same cycle, no bubble.
//  T5 illegal op: req1 op=11 data 0x1234_5678 -> resp_err=1, resp_data=0,
//   resp_src=1; next tie grants req0.
//  T6 random: 10k cycles random valid/op/data/shamt/resp_ready vs reference
//   model -> no lost/duplicated/reordered responses, no starvation > 1 grant.

Source files
------------

// File: rtl/shift_arbiter_2r.sv
// -----------------------------------------------------------------------------
// shift_arbiter_2r
//   Two requesters share one 32-bit barrel shifter (SLL/SRL/SRA). Round-robin
//   arbitration picks one request per cycle. The result is held in a single
//   registered response slot. Latency is 1 cycle and throughput is 1 op/cycle:
//   the slot can be reloaded in the same cycle that it drains.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   reqN_valid/ready        per-requester handshake (N = 0,1)
//   reqN_op                 00 SLL, 01 SRL, 10 SRA, 11 illegal
//   reqN_data, reqN_shamt   operand and shift amount
//   resp_valid/ready        response slot handshake
//   resp_data/src/err       result, issuing requester, illegal-op flag
// -----------------------------------------------------------------------------
module shift_arbiter_2r #(
    parameter  int DATA_W  = 32,
    localparam int SHAMT_W = $clog2(DATA_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [1:0]         req0_op,
    input  logic [DATA_W-1:0]  req0_data,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [1:0]         req1_op,
    input  logic [DATA_W-1:0]  req1_data,
    input  logic [SHAMT_W-1:0] req1_shamt,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [DATA_W-1:0]  resp_data,
    output logic               resp_src,
    output logic               resp_err
);

    typedef struct packed {
        logic [1:0]         op;
        logic [DATA_W-1:0]  data;
        logic [SHAMT_W-1:0] shamt;
    } req_t;

    logic              r_resp_valid;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_resp_src;
    logic              r_resp_err;
    logic              r_last_grant;

    req_t [1:0]        w_req;
    req_t              w_sel;
    logic              w_can_accept;
    logic              w_any_valid;
    logic              w_grant;
    logic              w_accept;
    logic [DATA_W-1:0] w_result;

    assign w_req[0] = '{op: req0_op, data: req0_data, shamt: req0_shamt};
    assign w_req[1] = '{op: req1_op, data: req1_data, shamt: req1_shamt};

    // The slot is free if it is empty, or if it is being drained this cycle.
    assign w_can_accept = !r_resp_valid || resp_ready;
    assign w_any_valid  = req0_valid || req1_valid;
    // On a tie, grant the requester that was not served last. Otherwise grant
    // whichever requester is valid. The value is a don't-care when idle.
    assign w_grant      = (req0_valid && req1_valid) ? !r_last_grant : req1_valid;
    // Gating with rst_n holds both readies low while reset is asserted.
    assign w_accept     = rst_n && w_can_accept && w_any_valid;

    assign req0_ready = w_accept && !w_grant;
    assign req1_ready = w_accept &&  w_grant;

    assign w_sel = w_req[w_grant];

    always_comb begin
        w_result = '0;
        case (w_sel.op)
            2'b00:   w_result = w_sel.data << w_sel.shamt;
            2'b01:   w_result = w_sel.data >> w_sel.shamt;
            2'b10:   w_result = $signed(w_sel.data) >>> w_sel.shamt;
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_src   <= 1'b0;
            r_resp_err   <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            // An accept can overlap a drain, so the slot reloads without a bubble.
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_result;
            r_resp_src   <= w_grant;
            r_resp_err   <= (w_sel.op == 2'b11);
            r_last_grant <= w_grant;
        end else if (r_resp_valid && resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_src   = r_resp_src;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_shift_arbiter_2r.sv
// -----------------------------------------------------------------------------
// tb_shift_arbiter_2r
//   Scoreboard bench. Each driven request queues its expected result per
//   requester. The acceptor checks the readies against a round-robin model and
//   moves accepted entries to the response queue. The monitor pops and
//   compares every response that is handed off, and checks that a stalled
//   slot stays stable.
// -----------------------------------------------------------------------------
module tb_shift_arbiter_2r;

    typedef struct {
        logic [31:0] d;
        logic        src;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v0, v1, resp_ready;
    logic        req0_ready, req1_ready;
    logic [1:0]  op0, op1;
    logic [31:0] d0, d1;
    logic [4:0]  sh0, sh1;
    logic        resp_valid, resp_src, resp_err;
    logic [31:0] resp_data;

    exp_t pend0[$];
    exp_t pend1[$];
    exp_t rq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   last_g;

    always #5 clk = ~clk;

    shift_arbiter_2r dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_ready(req0_ready), .req0_op(op0), .req0_data(d0), .req0_shamt(sh0),
        .req1_valid(v1), .req1_ready(req1_ready), .req1_op(op1), .req1_data(d1), .req1_shamt(sh1),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_src(resp_src), .resp_err(resp_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit-serial reference shifter, built independently of the RTL operators.
    function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                              input logic [4:0] sh);
        logic [31:0] r;
        r = d;
        for (int i = 0; i < 32; i++) begin
            if (i < int'(sh)) begin
                case (op)
                    2'd0:    r = {r[30:0], 1'b0};
                    2'd1:    r = {1'b0, r[31:1]};
                    2'd2:    r = {r[31], r[31:1]};
                    default: r = 32'h0;
                endcase
            end
        end
        if (op == 2'd3) r = 32'h0;
        return r;
    endfunction

    // Acceptor: checks the grant against the model and queues accepted ops.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_g = 1'b1;
            rq.delete();
            pend0.delete();
            pend1.delete();
        end else begin
            bit can, any, g;
            exp_t e;
            can = !resp_valid || resp_ready;
            any = v0 || v1;
            g   = (v0 && v1) ? !last_g : v1;
            check("ready0", {31'd0, req0_ready}, {31'd0, can && any && !g});
            check("ready1", {31'd0, req1_ready}, {31'd0, can && any && g});
            if (req0_ready || req1_ready) begin
                if (req0_ready && pend0.size() > 0) begin
                    e = pend0.pop_front(); rq.push_back(e); last_g = 1'b0;
                end else if (req1_ready && !req0_ready && pend1.size() > 0) begin
                    e = pend1.pop_front(); rq.push_back(e); last_g = 1'b1;
                end else begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_accept: r0=%0b r1=%0b with no pending op", req0_ready, req1_ready);
                end
            end
        end
    end

    // Monitor: compares handed-off responses and checks stability while stalled.
    bit          prev_stall;
    logic [31:0] pd;
    logic        ps, pe;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            exp_t e;
            if (prev_stall) begin
                check("hold_valid", {31'd0, resp_valid}, 32'd1);
                check("hold_data", resp_data, pd);
                check("hold_src", {31'd0, resp_src}, {31'd0, ps});
                check("hold_err", {31'd0, resp_err}, {31'd0, pe});
            end
            if (resp_valid && resp_ready) begin
                if (rq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_resp: data=%h src=%0b", resp_data, resp_src);
                end else begin
                    e = rq.pop_front();
                    check("resp_data", resp_data, e.d);
                    check("resp_src", {31'd0, resp_src}, {31'd0, e.src});
                    check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                end
            end
            prev_stall = resp_valid && !resp_ready;
            pd = resp_data; ps = resp_src; pe = resp_err;
        end
    end

    // Holds the request until it is accepted, then drops valid after the edge.
    task automatic issue(input int n, input logic [1:0] op, input logic [31:0] d,
                         input logic [4:0] sh, input logic [31:0] exp);
        exp_t e;
        int   cyc = 0;
        bit   got = 1'b0;
        e.d = exp; e.src = (n != 0); e.err = (op == 2'd3);
        if (n == 0) begin pend0.push_back(e); v0 = 1'b1; op0 = op; d0 = d; sh0 = sh; end
        else        begin pend1.push_back(e); v1 = 1'b1; op1 = op; d1 = d; sh1 = sh; end
        while (!got && cyc < 200) begin
            @(negedge clk);
            got = (n == 0) ? req0_ready : req1_ready;
            cyc++;
        end
        if (!got) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout: requester %0d not accepted in 200 cycles", n);
        end
        @(posedge clk); #1;
        if (n == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    logic [1:0]  t2_op [7] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd2, 2'd1, 2'd2};
    logic [31:0] t2_d  [7] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF,
                               32'h7000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [4:0]  t2_sh [7] = '{5'd31, 5'd4, 5'd4, 5'd0, 5'd4, 5'd31, 5'd31};
    logic [31:0] t2_x  [7] = '{32'h8000_0000, 32'h0800_0000, 32'hF800_0000, 32'hDEAD_BEEF,
                               32'h0700_0000, 32'h0000_0001, 32'hFFFF_FFFF};

    logic [1:0]  t3_op0 [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
    logic [31:0] t3_d0  [4] = '{32'h0000_00FF, 32'h1, 32'hF0, 32'h8000_0001};
    logic [4:0]  t3_sh0 [4] = '{5'd8, 5'd1, 5'd4, 5'd1};
    logic [31:0] t3_x0  [4] = '{32'h0000_FF00, 32'h2, 32'hF, 32'hC000_0000};
    logic [1:0]  t3_op1 [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
    logic [31:0] t3_d1  [4] = '{32'h1000, 32'hF000_0000, 32'hAAAA_AAAA, 32'hAAAA_AAAA};
    logic [4:0]  t3_sh1 [4] = '{5'd12, 5'd28, 5'd1, 5'd31};
    logic [31:0] t3_x1  [4] = '{32'h1, 32'hFFFF_FFFF, 32'h5555_5554, 32'h1};

    bit rdone;

    initial begin
        rst_n = 1'b0; v0 = 1'b1; v1 = 1'b1; resp_ready = 1'b0;
        op0 = '0; op1 = '0; d0 = '0; d1 = '0; sh0 = '0; sh1 = '0;
        #3;
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_data", resp_data, 32'd0);
        check("rst_r0", {31'd0, req0_ready}, 32'd0);
        check("rst_r1", {31'd0, req1_ready}, 32'd0);
        v0 = 1'b0; v1 = 1'b0;
        #19 rst_n = 1'b1;
        @(posedge clk); #1;

        // T2: single ops from requester 0, consumer always ready.
        resp_ready = 1'b1;
        for (int i = 0; i < 7; i++) issue(0, t2_op[i], t2_d[i], t2_sh[i], t2_x[i]);
        @(posedge clk); #1;

        // T3: both requesters back-to-back with no gaps.
        fork
            for (int i = 0; i < 4; i++) issue(0, t3_op0[i], t3_d0[i], t3_sh0[i], t3_x0[i]);
            for (int j = 0; j < 4; j++) issue(1, t3_op1[j], t3_d1[j], t3_sh1[j], t3_x1[j]);
        join
        @(posedge clk); #1;

        // T4: the slot stalls for 5 cycles, then drains and reloads in one cycle.
        resp_ready = 1'b0;
        issue(0, 2'd0, 32'h0000_0003, 5'd2, 32'h0000_000C);
        fork
            issue(0, 2'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
            begin repeat (5) @(posedge clk); #1; resp_ready = 1'b1; end
        join
        @(posedge clk); #1;

        // T5: an illegal op from requester 1, then a tie that goes to requester 0.
        issue(1, 2'd3, 32'h1234_5678, 5'd7, 32'h0);
        fork
            issue(0, 2'd1, 32'h0000_0100, 5'd8, 32'h0000_0001);
            issue(1, 2'd0, 32'h0000_0001, 5'd16, 32'h0001_0000);
        join
        @(posedge clk); #1;

        // T1: assert reset with a response pending and two requests waiting.
        resp_ready = 1'b0;
        issue(0, 2'd0, 32'h1, 5'd3, 32'h8);
        v0 = 1'b1; op0 = 2'd1; d0 = 32'hFF; sh0 = 5'd1;
        v1 = 1'b1; op1 = 2'd0; d1 = 32'hFF; sh1 = 5'd1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", {31'd0, resp_valid}, 32'd0);
        check("async_data", resp_data, 32'd0);
        check("async_src", {31'd0, resp_src}, 32'd0);
        check("async_err", {31'd0, resp_err}, 32'd0);
        check("async_r0", {31'd0, req0_ready}, 32'd0);
        check("async_r1", {31'd0, req1_ready}, 32'd0);
        v0 = 1'b0; v1 = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b1;
        fork
            issue(0, 2'd0, 32'h5, 5'd1, 32'hA);
            issue(1, 2'd1, 32'h5, 5'd1, 32'h2);
        join
        @(posedge clk); #1;

        // Random traffic with random backpressure, compared against the reference shifter.
        rdone = 1'b0;
        fork
            begin
                fork
                    for (int i = 0; i < 150; i++) begin
                        logic [1:0] o; logic [31:0] d; logic [4:0] s;
                        o = 2'($urandom_range(0, 3)); d = $urandom; s = 5'($urandom_range(0, 31));
                        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                        issue(0, o, d, s, ref_shift(o, d, s));
                    end
                    for (int j = 0; j < 150; j++) begin
                        logic [1:0] o; logic [31:0] d; logic [4:0] s;
                        o = 2'($urandom_range(0, 3)); d = $urandom; s = 5'($urandom_range(0, 31));
                        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                        issue(1, o, d, s, ref_shift(o, d, s));
                    end
                join
                rdone = 1'b1;
            end
            while (!rdone) begin
                @(posedge clk); #1;
                resp_ready = ($urandom_range(0, 3) != 0);
            end
        join

        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("drain_valid", {31'd0, resp_valid}, 32'd0);
        check("rq_empty", rq.size(), 32'd0);
        check("pend_empty", pend0.size() + pend1.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
